// File: rtl/minisrc_rtype_sequencer_if.sv
// Control bundle between the Mini-SRC R-type sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath/bench.
interface minisrc_rtype_sequencer_if #(
  parameter int NUM_REGS = 16
);
  logic                start;
  logic                mem_ready;
  logic [31:0]         ir;
  logic                PCout, MARin, IncPC, PCin, Read;
  logic                MDRin, MDRout, IRin, Yin;
  logic                Zlowin, Zhighin, Zlowout, Zhighout;
  logic                HIin, LOin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [4:0]          alu_op;
  logic                busy, done, fault;
  logic [3:0]          state_dbg;

  modport master (
    input  start, mem_ready, ir,
    output PCout, MARin, IncPC, PCin, Read,
    output MDRin, MDRout, IRin, Yin,
    output Zlowin, Zhighin, Zlowout, Zhighout,
    output HIin, LOin, Rin, Rout, alu_op,
    output busy, done, fault, state_dbg
  );

  modport slave (
    output start, mem_ready, ir,
    input  PCout, MARin, IncPC, PCin, Read,
    input  MDRin, MDRout, IRin, Yin,
    input  Zlowin, Zhighin, Zlowout, Zhighout,
    input  HIin, LOin, Rin, Rout, alu_op,
    input  busy, done, fault, state_dbg
  );
endinterface

// File: rtl/minisrc_rtype_sequencer.sv
// T0..T6 control-step sequencer for Mini-SRC three-register ALU ops.
// Outputs decode the registered state plus ir; FAULT is sticky until clear.
module minisrc_rtype_sequencer #(
  parameter int          NUM_REGS    = 16,
  parameter logic [4:0]  MUL_OP      = 5'b01111,
  parameter logic [4:0]  DIV_OP      = 5'b10000,
  parameter logic [31:0] ALU_OP_MASK = 32'h0001FFF8,
  parameter int          MEM_TIMEOUT = 8
) (
  input logic clock,
  input logic clear,
  minisrc_rtype_sequencer_if.master bus
);
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [4:0] NR = 5'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_DONE  = 4'd8,
    S_FAULT = 4'd15
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       legal, mul_div;

  assign op = bus.ir[31:27];
  assign ra = bus.ir[26:23];
  assign rb = bus.ir[22:19];
  assign rc = bus.ir[18:15];

  assign mul_div = (op == MUL_OP) || (op == DIV_OP);
  assign legal   = ALU_OP_MASK[op]
                 && ({1'b0, ra} < NR)
                 && ({1'b0, rb} < NR)
                 && ({1'b0, rc} < NR);

  // State register and T1 wait counter (counter resets outside T1 waits).
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_T1 && !bus.mem_ready) cnt <= cnt + 1'b1;
      else                                 cnt <= '0;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = bus.start ? S_T0 : S_IDLE;
      S_T0:    state_nx = S_T1;
      S_T1: begin
        if (bus.mem_ready)        state_nx = S_T2;
        else if (cnt == CNT_LAST) state_nx = S_FAULT;
        else                      state_nx = S_T1;
      end
      S_T2:    state_nx = S_T3;
      S_T3:    state_nx = legal ? S_T4 : S_FAULT;
      S_T4:    state_nx = S_T5;
      S_T5:    state_nx = mul_div ? S_T6 : S_DONE;
      S_T6:    state_nx = S_DONE;
      S_DONE:  state_nx = bus.start ? S_T0 : S_IDLE;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-state strobe decode; register selects are gated by legality.
  always_comb begin
    bus.PCout = 1'b0; bus.MARin = 1'b0; bus.IncPC = 1'b0;
    bus.PCin = 1'b0; bus.Read = 1'b0; bus.MDRin = 1'b0;
    bus.MDRout = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
    bus.Zlowin = 1'b0; bus.Zhighin = 1'b0;
    bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
    bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.Rin = '0; bus.Rout = '0; bus.alu_op = 5'd0;
    bus.busy = 1'b0; bus.done = 1'b0; bus.fault = 1'b0;
    bus.state_dbg = state;
    unique case (state)
      S_IDLE: ;
      S_T0: begin
        bus.busy = 1'b1;
        bus.PCout = 1'b1; bus.MARin = 1'b1;
        bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
      end
      S_T1: begin
        bus.busy = 1'b1;
        bus.Zlowout = 1'b1; bus.PCin = 1'b1;
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.busy = 1'b1;
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        bus.busy = 1'b1;
        if (legal) begin
          bus.Yin = 1'b1;
          for (int i = 0; i < NUM_REGS; i++)
            bus.Rout[i] = (rb == 4'(i));
        end
      end
      S_T4: begin
        bus.busy = 1'b1;
        if (legal) begin
          bus.alu_op = op;
          bus.Zlowin = 1'b1;
          bus.Zhighin = mul_div;
          for (int i = 0; i < NUM_REGS; i++)
            bus.Rout[i] = (rc == 4'(i));
        end
      end
      S_T5: begin
        bus.busy = 1'b1;
        bus.Zlowout = 1'b1;
        if (mul_div) bus.LOin = 1'b1;
        else if (legal)
          for (int i = 0; i < NUM_REGS; i++)
            bus.Rin[i] = (ra == 4'(i));
      end
      S_T6: begin
        bus.busy = 1'b1;
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      S_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end
endmodule
